// File: rtl/placar_7s.sv
// placar_7s: multi-digit decimal score driver for active-low 7-segment displays.
// A binary value is converted to BCD by a sequential shift-and-add-3 engine.
// Each digit is then encoded with the 0-9 glyph set. The result can blank
// leading zeros and shows "-" on every digit when the value does not fit.
//
// Handshake: carregar is accepted on a rising edge only while ocupado=0.
// ocupado stays high from the acceptance edge until the edge that raises pronto.
// pronto is a single-cycle pulse, and segmentos/estouro change on that same edge.
// A request made while ocupado=1 is dropped, not queued.
`timescale 1ns/1ps

module placar_7s #(
  parameter int DIGITOS = 4,
  parameter int LARGURA = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LARGURA-1:0]     valor,
  input  logic                   carregar,
  input  logic                   apagar_zeros,
  output logic                   ocupado,
  output logic                   pronto,
  output logic                   estouro,
  output logic [7*DIGITOS-1:0]   segmentos,
  output logic                   estado_dbg
);

  localparam int NB = 4 * DIGITOS;
  localparam int CW = $clog2(LARGURA + 1);

  // 10^n as a 64-bit constant; 10^8 still fits comfortably.
  function automatic logic [63:0] pot10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] LIMITE = pot10(DIGITOS);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Active-low glyph encoding, gfedcba. Invalid nibbles are shown as blank.
  function automatic logic [6:0] glifo(input logic [3:0] n);
    case (n)
      4'd0:    glifo = 7'b1000000;
      4'd1:    glifo = 7'b1111001;
      4'd2:    glifo = 7'b0100100;
      4'd3:    glifo = 7'b0110000;
      4'd4:    glifo = 7'b0011001;
      4'd5:    glifo = 7'b0010010;
      4'd6:    glifo = 7'b0000010;
      4'd7:    glifo = 7'b1111000;
      4'd8:    glifo = 7'b0000000;
      4'd9:    glifo = 7'b0010000;
      default: glifo = SEG_BLANK;
    endcase
  endfunction

  typedef enum logic {
    OCIOSO   = 1'b0,
    CONVERTE = 1'b1
  } estado_t;

  estado_t              estado_q, estado_d;
  logic [LARGURA-1:0]   bin_q, bin_d;
  logic [NB-1:0]        bcd_q, bcd_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 apaga_q, apaga_d;
  logic                 ovf_q, ovf_d;
  logic                 pronto_q, pronto_d;
  logic                 estouro_q, estouro_d;
  logic [7*DIGITOS-1:0] seg_q, seg_d;

  logic [NB-1:0]        bcd_adj;
  logic [NB-1:0]        bcd_sh;
  logic [7*DIGITOS-1:0] seg_novo;

  // Double-dabble step: add 3 to every nibble >= 5, then shift in the next binary bit.
  always_comb begin
    logic [3:0] nib;
    bcd_adj = '0;
    for (int i = 0; i < DIGITOS; i++) begin
      nib = bcd_q[4*i +: 4];
      if (nib >= 4'd5) nib = nib + 4'd3;
      bcd_adj[4*i +: 4] = nib;
    end
    bcd_sh = {bcd_adj[NB-2:0], bin_q[LARGURA-1]};
  end

  // Glyph encoding of the shifted BCD value, with optional leading-zero blanking.
  // A digit is blank only when it and every digit above it are zero.
  // Digit 0 is never blanked.
  always_comb begin
    logic [3:0] nib;
    logic       nz_acima;
    seg_novo = '1;
    nz_acima = 1'b0;
    for (int i = DIGITOS - 1; i >= 0; i--) begin
      nib = bcd_sh[4*i +: 4];
      if (nib != 4'd0) nz_acima = 1'b1;
      if (i != 0 && apaga_q && !nz_acima) seg_novo[7*i +: 7] = SEG_BLANK;
      else                                seg_novo[7*i +: 7] = glifo(nib);
    end
  end

  // Next-state logic: latch on acceptance, shift LARGURA times, then publish the result.
  always_comb begin
    estado_d  = estado_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    apaga_d   = apaga_q;
    ovf_d     = ovf_q;
    pronto_d  = 1'b0;
    estouro_d = estouro_q;
    seg_d     = seg_q;
    case (estado_q)
      OCIOSO: begin
        if (carregar) begin
          bin_d    = valor;
          apaga_d  = apagar_zeros;
          bcd_d    = '0;
          cnt_d    = CW'(LARGURA);
          // The overflow decision is taken now, so the BCD overflow bits never matter.
          ovf_d    = (64'(valor) >= LIMITE);
          estado_d = CONVERTE;
        end
      end
      CONVERTE: begin
        bcd_d = bcd_sh;
        bin_d = bin_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          estado_d  = OCIOSO;
          pronto_d  = 1'b1;
          estouro_d = ovf_q;
          seg_d     = ovf_q ? {DIGITOS{SEG_DASH}} : seg_novo;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // State and datapath registers; reset returns to idle with a blank display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q  <= OCIOSO;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      apaga_q   <= 1'b0;
      ovf_q     <= 1'b0;
      pronto_q  <= 1'b0;
      estouro_q <= 1'b0;
      seg_q     <= '1;
    end else begin
      estado_q  <= estado_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      apaga_q   <= apaga_d;
      ovf_q     <= ovf_d;
      pronto_q  <= pronto_d;
      estouro_q <= estouro_d;
      seg_q     <= seg_d;
    end
  end

  assign ocupado    = (estado_q == CONVERTE);
  assign pronto     = pronto_q;
  assign estouro    = estouro_q;
  assign segmentos  = seg_q;
  assign estado_dbg = estado_q;

endmodule

// File: doc/placar_7s.md
# placar_7s

Parametrised multi-digit score display driver for the Breakout board's active-low seven-segment displays. A binary value is converted to BCD with a sequential shift-and-add-3 (double-dabble) engine. Each BCD digit is then encoded with the standard 0-9 glyph set, with optional leading-zero blanking and overflow indication. It sits between the game logic (score/lives counters) and the HEX display pins, and replaces per-digit hex decoding for decimal readouts.

## Interface

- DIGITOS, 4: number of decimal digits driven (1-8).
- LARGURA, 14: width of the binary input value (1-27).
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- valor  input  LARGURA  unsigned binary value to display; sampled when carregar is accepted.
- carregar  input  1  request a conversion; accepted only when ocupado=0.
- apagar_zeros  input  1  leading-zero blanking enable; sampled with valor.
- ocupado  output  1  conversion in progress.
- pronto  output  1  one-cycle pulse; segmentos/estouro updated on the same edge.
- estouro  output  1  last accepted valor ≥ 10^DIGITOS.
- segmentos  output  7*DIGITOS  active-low segments; digit i at [7i+6:7i], digit 0 least significant; bit 0 = a … bit 6 = g.

## Operation

- FSM states: OCIOSO, CONVERTE.
- OCIOSO: when carregar=1, latch valor into a shift register and apagar_zeros into a flag. Clear the BCD register (4*DIGITOS bits), load the bit counter with LARGURA, and go to CONVERTE. Otherwise hold.
- CONVERTE: each cycle, add 3 to every BCD nibble ≥5, then shift {BCD, binary} left by one bit. Decrement the counter. After the LARGURA-th shift, go to OCIOSO and perform the output update on that same edge.
- Overflow: compare the latched valor against the constant 10^DIGITOS at latch time. If valor ≥ 10^DIGITOS, estouro=1 and every digit shows "-" (7'b0111111). The BCD result is discarded.
- Glyphs (active-low, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111
- Blanking: with the flag set, every zero digit above the most significant nonzero digit is blank. Digit 0 is never blanked, so value 0 shows a single "0".
- Nibbles >9 cannot occur; if the encoder receives one, it outputs blank.
- segmentos and estouro are registered and hold their previous value during conversion (no flicker).
- carregar while ocupado=1 is ignored (not queued).

## Timing

- Reset values:
  - state=OCIOSO
  - ocupado=0, pronto=0, estouro=0
  - segmentos all ones (every digit blank)
- Acceptance edge E0: carregar=1 in OCIOSO. ocupado=1 from E0.
- Shifts on edges E1…E_LARGURA. On edge E_LARGURA:
  - segmentos and estouro take their new values
  - pronto=1 for exactly one cycle
  - ocupado=0
- Total latency is LARGURA edges after acceptance: 14 cycles at defaults.
- carregar sampled high in the cycle where pronto=1 is accepted immediately. Held high, carregar gives back-to-back conversions every LARGURA+1 cycles.
- valor and apagar_zeros may change freely while ocupado=1; only the values at acceptance count.
- rst asserted mid-conversion: immediate return to reset values. No pronto is produced, and the pending conversion is lost.

## Test plan

- Reset: assert rst asynchronously mid-cycle → segmentos=28'hFFFFFFF, ocupado=0, pronto=0, estouro=0, without waiting for an edge.
- valor=1234, apagar_zeros=0, 1-cycle carregar → pronto exactly 14 cycles later. Digits 3..0 = 1111001, 0100100, 0110000, 0011001; estouro=0; ocupado high for 14 cycles.
- valor=7, apagar_zeros=1 → digits 3..1 blank (1111111), digit 0 = 1111000.
- valor=0, apagar_zeros=1 → digit 0 = 1000000, others blank.
- valor=0, apagar_zeros=0 → all four digits 1000000.
- valor=10000 and valor=16383 → estouro=1, all digits 0111111. Then valor=9999 → estouro=0, all digits 0010000.
- Collisions and reset:
  - carregar pulsed at cycle 5 of a conversion of 42 → ignored; one pronto only, display "42".
  - rst at cycle 7 of a conversion → no pronto; display blank.
- Back-to-back: carregar held high with valor stepping 1,2,3 → pronto every 15 cycles, showing 1, 2, 3 in order.
